fetch_queue: RTL and testbench

- Instruction decoupling buffer between the fetch stage and the IF/ID latch / decode stage.
- Each entry holds one fetched instruction, its PC+2 and its fetch-err bit.
- Absorbs short decode stalls so fetch keeps running. Drives the fetch-stage stall when full, and is emptied on redirect (taken branch/jump).
- Stops accepting fetches once a HALT has been queued.

---
 rtl/fetch_queue.sv | 105 ++++++++++
 tb/tb_fetch_queue.sv | 298 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fetch_queue.sv
// Fetch-to-decode instruction queue: circular buffer of {instr, pc2, err}, sticky HALT stop, flush on redirect.
// Optional same-cycle empty-queue bypass when FETCH_QUEUE_BYPASS_EN is defined.
module fetch_queue #(
    parameter int          ADDR_W    = 2,
    parameter logic [15:0] NOP_INSTR = 16'h0800,
    parameter logic [4:0]  HALT_OPC  = 5'b00000
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              push,
    input  logic [15:0]       push_instr,
    input  logic [15:0]       push_pc2,
    input  logic              push_err,
    output logic              full,
    input  logic              pop,
    input  logic              flush,
    output logic              out_valid,
    output logic [15:0]       out_instr,
    output logic [15:0]       out_pc2,
    output logic              out_err,
    output logic [ADDR_W:0]   count,
    output logic              halt_q
);

    localparam int              DEPTH   = 1 << ADDR_W;
    localparam logic [ADDR_W:0] DEPTH_C = (ADDR_W + 1)'(DEPTH);

    logic [15:0]       mem_instr [DEPTH];
    logic [15:0]       mem_pc2   [DEPTH];
    logic              mem_err   [DEPTH];
    logic [ADDR_W-1:0] rd_ptr;
    logic [ADDR_W-1:0] wr_ptr;

    logic stored_valid;
    logic pop_acc;
    logic push_acc;
    logic bypass;
    logic wr_en;
    logic rd_en;
    logic is_halt;

    always_comb begin
        stored_valid = (count != '0);
        pop_acc      = pop & stored_valid;
        push_acc     = push & ~flush & ~halt_q & ((count < DEPTH_C) | pop_acc);
`ifdef FETCH_QUEUE_BYPASS_EN
        bypass       = ~stored_valid & push_acc & pop;
`else
        bypass       = 1'b0;
`endif
        // A bypassed entry is handed straight to decode and never stored
        wr_en        = push_acc & ~bypass;
        rd_en        = pop_acc;
        is_halt      = (push_instr[15:11] == HALT_OPC);
        out_valid    = stored_valid | bypass;
        full         = (count == DEPTH_C) | halt_q;

        out_instr    = NOP_INSTR;
        out_pc2      = 16'h0000;
        out_err      = 1'b0;
        if (bypass) begin
            out_instr = push_instr;
            out_pc2   = push_pc2;
            out_err   = push_err;
        end else if (stored_valid) begin
            out_instr = mem_instr[rd_ptr];
            out_pc2   = mem_pc2[rd_ptr];
            out_err   = mem_err[rd_ptr];
        end
    end

    // Storage: data only, no reset
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem_instr[wr_ptr] <= push_instr;
            mem_pc2[wr_ptr]   <= push_pc2;
            mem_err[wr_ptr]   <= push_err;
        end
    end

    // Control: pointers, occupancy and sticky halt
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
            halt_q <= 1'b0;
        end else if (flush) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
            halt_q <= 1'b0;
        end else begin
            if (wr_en) wr_ptr <= wr_ptr + 1'b1;
            if (rd_en) rd_ptr <= rd_ptr + 1'b1;
            case ({wr_en, rd_en})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
            if (push_acc && is_halt) halt_q <= 1'b1;
        end
    end

endmodule

// File: tb/tb_fetch_queue.sv
// Bench for fetch_queue: vector table, directed corner sequences and random traffic against a queue model.
module tb_fetch_queue;

    logic        clk;
    logic        rst;
    logic        push;
    logic [15:0] push_instr;
    logic [15:0] push_pc2;
    logic        push_err;
    logic        full;
    logic        pop;
    logic        flush;
    logic        out_valid;
    logic [15:0] out_instr;
    logic [15:0] out_pc2;
    logic        out_err;
    logic [2:0]  count;
    logic        halt_q;

    fetch_queue dut (
        .clk(clk), .rst(rst), .push(push), .push_instr(push_instr), .push_pc2(push_pc2),
        .push_err(push_err), .full(full), .pop(pop), .flush(flush), .out_valid(out_valid),
        .out_instr(out_instr), .out_pc2(out_pc2), .out_err(out_err), .count(count), .halt_q(halt_q)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    typedef struct {
        logic [15:0] instr;
        logic [15:0] pc2;
        logic        err;
    } ent_t;

    ent_t mq[$];
    bit   mh;

    typedef struct {
        bit          p;
        logic [15:0] instr;
        bit          po;
        bit          fl;
        bit          ev;
        logic [15:0] ei;
        int          ecnt;
        bit          efull;
    } vec_t;

    vec_t tbl[10];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic drive(input bit p, input logic [15:0] instr, input logic [15:0] pc2,
                         input bit err, input bit po, input bit fl);
        push       = p;
        push_instr = instr;
        push_pc2   = pc2;
        push_err   = err;
        pop        = po;
        flush      = fl;
    endtask

    task automatic dp(input bit p, input logic [15:0] instr, input bit po, input bit fl);
        drive(p, instr, instr ^ 16'h5A5A, instr[0], po, fl);
    endtask

    function automatic bit model_bypass();
        bit b;
        b = 1'b0;
`ifdef FETCH_QUEUE_BYPASS_EN
        b = (mq.size() == 0) && push && !flush && !mh && pop;
`endif
        return b;
    endfunction

    task automatic check_model();
        bit          byp;
        bit          ev;
        logic [15:0] ei;
        logic [15:0] ep;
        bit          ee;
        byp = model_bypass();
        ev  = (mq.size() != 0) || byp;
        ei  = 16'h0800;
        ep  = 16'h0000;
        ee  = 1'b0;
        if (byp) begin
            ei = push_instr; ep = push_pc2; ee = push_err;
        end else if (mq.size() != 0) begin
            ei = mq[0].instr; ep = mq[0].pc2; ee = mq[0].err;
        end
        chk("m_valid", 32'(out_valid), 32'(ev));
        chk("m_instr", 32'(out_instr), 32'(ei));
        chk("m_pc2",   32'(out_pc2),   32'(ep));
        chk("m_err",   32'(out_err),   32'(ee));
        chk("m_count", 32'(count),     32'(mq.size()));
        chk("m_full",  32'(full),      32'((mq.size() == 4) || mh));
        chk("m_halt",  32'(halt_q),    32'(mh));
    endtask

    task automatic clock_model();
        bit   p, po, fl, byp, pop_ok, push_ok;
        ent_t e;
        p      = push;
        po     = pop;
        fl     = flush;
        e      = '{push_instr, push_pc2, push_err};
        byp    = model_bypass();
        pop_ok = po && (mq.size() > 0);
        push_ok = p && !fl && !mh && ((mq.size() < 4) || pop_ok);
        @(posedge clk);
        if (fl) begin
            mq.delete();
            mh = 1'b0;
        end else begin
            if (!byp) begin
                if (pop_ok) void'(mq.pop_front());
                if (push_ok) mq.push_back(e);
            end
            if (push_ok && (e.instr[15:11] == 5'b00000)) mh = 1'b1;
        end
        #1;
    endtask

    task automatic run_cycle();
        #3;
        check_model();
        clock_model();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1, "timeout");
    end

    initial begin
        mh  = 1'b0;
        rst = 1'b0;
        dp(0, 16'h0, 0, 0);
        repeat (2) @(posedge clk);
        #1 rst = 1'b1;

        // Reset state and idle
        #2;
        chk("rst_valid", 32'(out_valid), 32'd0);
        chk("rst_instr", 32'(out_instr), 32'h0800);
        chk("rst_pc2",   32'(out_pc2),   32'd0);
        chk("rst_count", 32'(count),     32'd0);
        chk("rst_full",  32'(full),      32'd0);
        run_cycle();

        // Asynchronous reset with three entries queued
        for (int i = 0; i < 3; i++) begin
            dp(1, 16'h1100 + 16'(i), 0, 0);
            run_cycle();
        end
        dp(0, 16'h0, 0, 0);
        #2 chk("pre_arst_count", 32'(count), 32'd3);
        #1 rst = 1'b0;
        #1;
        chk("arst_count", 32'(count),     32'd0);
        chk("arst_valid", 32'(out_valid), 32'd0);
        chk("arst_instr", 32'(out_instr), 32'h0800);
        mq.delete();
        mh = 1'b0;
        #2 rst = 1'b1;
        @(posedge clk);
        #1;

        // Table: fill to full, refused fifth push, drain in order
        tbl[0] = '{1, 16'h1111, 0, 0, 0, 16'h0800, 0, 0};
        tbl[1] = '{1, 16'h2222, 0, 0, 1, 16'h1111, 1, 0};
        tbl[2] = '{1, 16'h3333, 0, 0, 1, 16'h1111, 2, 0};
        tbl[3] = '{1, 16'h4444, 0, 0, 1, 16'h1111, 3, 0};
        tbl[4] = '{1, 16'h5555, 0, 0, 1, 16'h1111, 4, 1};
        tbl[5] = '{0, 16'h0000, 1, 0, 1, 16'h1111, 4, 1};
        tbl[6] = '{0, 16'h0000, 1, 0, 1, 16'h2222, 3, 0};
        tbl[7] = '{0, 16'h0000, 1, 0, 1, 16'h3333, 2, 0};
        tbl[8] = '{0, 16'h0000, 1, 0, 1, 16'h4444, 1, 0};
        tbl[9] = '{0, 16'h0000, 0, 0, 0, 16'h0800, 0, 0};
        for (int i = 0; i < 10; i++) begin
            dp(tbl[i].p, tbl[i].instr, tbl[i].po, tbl[i].fl);
            #2;
            chk($sformatf("tbl%0d_valid", i), 32'(out_valid), 32'(tbl[i].ev));
            chk($sformatf("tbl%0d_instr", i), 32'(out_instr), 32'(tbl[i].ei));
            chk($sformatf("tbl%0d_count", i), 32'(count),     32'(tbl[i].ecnt));
            chk($sformatf("tbl%0d_full",  i), 32'(full),      32'(tbl[i].efull));
            run_cycle();
        end

        // Full queue with simultaneous push and pop across pointer wrap
        for (int i = 0; i < 4; i++) begin
            dp(1, 16'h1000 + 16'(i), 0, 0);
            run_cycle();
        end
        for (int i = 0; i < 8; i++) begin
            dp(1, 16'hA000 + 16'(i), 1, 0);
            #2 chk("wrap_count", 32'(count), 32'd4);
            run_cycle();
        end
        dp(0, 16'h0, 0, 0);
        #2;
        chk("wrap_head",  32'(out_instr), 32'hA004);
        chk("wrap_count_end", 32'(count), 32'd4);
        run_cycle();
        dp(0, 16'h0, 0, 1);
        run_cycle();

        // HALT stops intake; queued entries still drain; flush clears
        dp(1, 16'h2222, 0, 0); run_cycle();
        dp(1, 16'h0000, 0, 0); run_cycle();
        dp(0, 16'h0, 0, 0);
        #2;
        chk("halt_set",  32'(halt_q), 32'd1);
        chk("halt_full", 32'(full),   32'd1);
        run_cycle();
        dp(1, 16'h3333, 0, 0); run_cycle();
        dp(0, 16'h0, 0, 0);
        #2 chk("halt_refused_count", 32'(count), 32'd2);
        dp(0, 16'h0, 1, 0);
        #2 chk("halt_head1", 32'(out_instr), 32'h2222);
        run_cycle();
        dp(0, 16'h0, 1, 0);
        #2 chk("halt_head2", 32'(out_instr), 32'h0000);
        chk("halt_head2_valid", 32'(out_valid), 32'd1);
        run_cycle();
        dp(0, 16'h0, 0, 0);
        #2;
        chk("halt_drained", 32'(out_valid), 32'd0);
        chk("halt_sticky",  32'(halt_q),    32'd1);
        run_cycle();
        dp(0, 16'h0, 0, 1); run_cycle();
        dp(0, 16'h0, 0, 0);
        #2;
        chk("halt_clear", 32'(halt_q), 32'd0);
        chk("halt_clear_full", 32'(full), 32'd0);
        run_cycle();

        // push + pop + flush together with three entries
        for (int i = 0; i < 3; i++) begin
            dp(1, 16'h6100 + 16'(i), 0, 0);
            run_cycle();
        end
        dp(1, 16'h9999, 1, 1);
        #2 chk("ppf_pre_count", 32'(count), 32'd3);
        run_cycle();
        dp(0, 16'h0, 0, 0);
        #2;
        chk("ppf_count", 32'(count),     32'd0);
        chk("ppf_valid", 32'(out_valid), 32'd0);
        run_cycle();
        run_cycle();

        // Empty queue, push with pop in the same cycle
        dp(1, 16'h7777, 1, 0);
        #2;
`ifdef FETCH_QUEUE_BYPASS_EN
        chk("byp_valid", 32'(out_valid), 32'd1);
        chk("byp_instr", 32'(out_instr), 32'h7777);
`else
        chk("byp_valid", 32'(out_valid), 32'd0);
        chk("byp_instr", 32'(out_instr), 32'h0800);
`endif
        run_cycle();
        dp(0, 16'h0, 0, 0);
        #2;
`ifdef FETCH_QUEUE_BYPASS_EN
        chk("byp_next_count", 32'(count),     32'd0);
        chk("byp_next_valid", 32'(out_valid), 32'd0);
`else
        chk("byp_next_count", 32'(count),     32'd1);
        chk("byp_next_instr", 32'(out_instr), 32'h7777);
`endif
        run_cycle();
        dp(0, 16'h0, 1, 0); run_cycle();

        // Random traffic
        for (int i = 0; i < 600; i++) begin
            drive($urandom_range(0, 3) != 0, 16'($urandom), 16'($urandom), 1'($urandom),
                  $urandom_range(0, 2) != 0, $urandom_range(0, 24) == 0);
            run_cycle();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
